// File: rtl/elevator_dispatch.sv
// ----------------------------------------------------------------------------
// elevator_dispatch
//
// Dispatch controller for a four-floor elevator car. It latches floor calls,
// chooses a travel direction with a SCAN policy (keep going while there is
// work ahead, otherwise turn around), and commands an external floor
// sequencer one floor at a time through single-cycle step pulses. Arrival at
// a requested floor opens the door for DOOR_CYC cycles.
//
// Parameters
//   TRAVEL_CYC  cycles spent travelling one floor (2..255)
//   DOOR_CYC    cycles the door stays open per stop (1..255)
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   call[3:0]  in   level-sensitive floor call buttons, bit i = floor i
//   step       out  one-cycle pulse: move one floor in direction dir
//   dir        out  1 = up, 0 = down; held between steps
//   floor[1:0] out  current floor as tracked by this block
//   pending    out  latched outstanding requests
//   door_open  out  high while stopped with the door open
//   busy       out  high whenever the controller is not idle
//   state[1:0] out  FSM state for observation (0 IDLE, 1 MOVE, 2 DOOR)
//   seg[0:6]   out  only with DISPATCH_SEG_EN defined: registered,
//                   active-low seven-segment digit showing floor+1
//
// Configuration macro: DISPATCH_SEG_EN (adds the seg output and its logic).
//
// Handshake: there is no back-pressure. A step pulse is a command that the
// sequencer is assumed to accept in the same cycle; dir is valid whenever
// step is high and stays constant until the next step.
// ----------------------------------------------------------------------------
module elevator_dispatch #(
   parameter int TRAVEL_CYC = 8,
   parameter int DOOR_CYC   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] call,
   output logic       step,
   output logic       dir,
   output logic [1:0] floor,
   output logic [3:0] pending,
   output logic       door_open,
   output logic       busy,
   output logic [1:0] state
`ifdef DISPATCH_SEG_EN
   ,
   output logic [0:6] seg
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MOVE = 2'd1;
   localparam logic [1:0] DOOR = 2'd2;

   // Timers count down to zero; the action happens in the cycle where the
   // timer reads zero, so loading N-1 gives exactly N cycles in the state.
   localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYC - 1);
   localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYC - 1);

   // -------------------------------------------------------------------------
   // Registered state
   // -------------------------------------------------------------------------
   logic [1:0] state_q;
   logic [1:0] floor_q;
   logic       dir_q;
   logic [3:0] pending_q;
   logic [7:0] timer_q;

   // Next-state values
   logic [1:0] state_n;
   logic [1:0] floor_n;
   logic       dir_n;
   logic [3:0] pending_n;
   logic [7:0] timer_n;

   // Helpers
   logic [3:0] req_now;       // latched requests plus calls arriving now
   logic       step_fire;     // last travel cycle of a floor
   logic [1:0] floor_arrive;  // floor reached at the end of this step
   logic       scan_up;       // direction chosen when leaving IDLE
   logic       more_ahead;    // requests beyond the arrival floor in dir

   // True if any bit of m lies strictly above floor f.
   function automatic logic any_above(input logic [3:0] m, input logic [1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(f)) r = r | m[i];
      end
      return r;
   endfunction

   // True if any bit of m lies strictly below floor f.
   function automatic logic any_below(input logic [3:0] m, input logic [1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(f)) r = r | m[i];
      end
      return r;
   endfunction

   assign req_now   = pending_q | call;
   assign step_fire = (state_q == MOVE) && (timer_q == 8'd0);

   // Saturating floor update. A legal direction is always chosen before
   // MOVE, so saturation only guards against ever wrapping 3 -> 0 or 0 -> 3.
   always_comb begin
      floor_arrive = floor_q;
      if (dir_q && (floor_q != 2'd3)) begin
         floor_arrive = floor_q + 2'd1;
      end else if (!dir_q && (floor_q != 2'd0)) begin
         floor_arrive = floor_q - 2'd1;
      end
   end

   // SCAN choice from IDLE: keep the previous direction if there is work
   // beyond the car in that direction, otherwise reverse. The end floors
   // force the only direction that makes sense.
   always_comb begin
      if (floor_q == 2'd0) begin
         scan_up = 1'b1;
      end else if (floor_q == 2'd3) begin
         scan_up = 1'b0;
      end else if (dir_q) begin
         scan_up = any_above(pending_q, floor_q);
      end else begin
         scan_up = !any_below(pending_q, floor_q);
      end
   end

   assign more_ahead = dir_q ? any_above(req_now, floor_arrive)
                             : any_below(req_now, floor_arrive);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_n = state_q;
      floor_n = floor_q;
      dir_n   = dir_q;
      timer_n = timer_q;

      case (state_q)
         IDLE: begin
            if (pending_q[floor_q]) begin
               state_n = DOOR;
               timer_n = DOOR_LOAD;
            end else if (pending_q != 4'd0) begin
               state_n = MOVE;
               dir_n   = scan_up;
               timer_n = TRAVEL_LOAD;
            end
         end

         MOVE: begin
            if (!step_fire) begin
               timer_n = timer_q - 8'd1;
            end else begin
               floor_n = floor_arrive;
               // req_now includes this cycle's calls, so a button pressed at
               // the floor being reached right now still stops the car.
               if (req_now[floor_arrive]) begin
                  state_n = DOOR;
                  timer_n = DOOR_LOAD;
               end else if (more_ahead) begin
                  state_n = MOVE;
                  timer_n = TRAVEL_LOAD;
               end else begin
                  // Only work behind the car remains; IDLE turns it around.
                  state_n = IDLE;
                  timer_n = 8'd0;
               end
            end
         end

         DOOR: begin
            // A call at this floor holds the door: restart the full period.
            if (call[floor_q]) begin
               timer_n = DOOR_LOAD;
            end else if (timer_q != 8'd0) begin
               timer_n = timer_q - 8'd1;
            end else begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
            timer_n = 8'd0;
         end
      endcase

      // The floor being served is never left latched while the door is open.
      pending_n = req_now;
      if (state_n == DOOR) begin
         pending_n[floor_n] = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         floor_q   <= 2'd0;
         dir_q     <= 1'b1;
         pending_q <= 4'd0;
         timer_q   <= 8'd0;
      end else begin
         state_q   <= state_n;
         floor_q   <= floor_n;
         dir_q     <= dir_n;
         pending_q <= pending_n;
         timer_q   <= timer_n;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // step is qualified with rst_n so that a reset asserted in the very cycle
   // a step would fire suppresses the pulse.
   assign step      = step_fire && rst_n;
   assign dir       = dir_q;
   assign floor     = floor_q;
   assign pending   = pending_q;
   assign door_open = (state_q == DOOR);
   assign busy      = (state_q != IDLE);
   assign state     = state_q;

`ifdef DISPATCH_SEG_EN
   // Active-low segments a..g on seg[0..6]; digit shown is floor+1 and
   // trails the floor register by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg <= 7'b1001111;
      end else begin
         case (floor_q)
            2'd0:    seg <= 7'b1001111;
            2'd1:    seg <= 7'b0010010;
            2'd2:    seg <= 7'b0000110;
            default: seg <= 7'b1001100;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_elevator_dispatch.sv
// ----------------------------------------------------------------------------
// tb_elevator_dispatch
//
// Bench for elevator_dispatch (TRAVEL_CYC = 8, DOOR_CYC = 5). Each scenario
// pushes the events it expects (step pulses, door openings, door closings
// with their open length) onto exp_q before driving calls; a monitor on the
// falling clock edge turns DUT activity into the same event encoding and
// pops/compares. Event word: {kind[1:0], dir, floor[1:0], aux[6:0]} where aux
// is the cycle gap since the car last became busy / last step (step, open)
// or the number of door-open cycles (close).
// ----------------------------------------------------------------------------
module tb_elevator_dispatch;

   localparam int TRAVEL_CYC = 8;
   localparam int DOOR_CYC   = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MOVE = 2'd1;

   localparam logic [1:0] K_STEP  = 2'd1;
   localparam logic [1:0] K_OPEN  = 2'd2;
   localparam logic [1:0] K_CLOSE = 2'd3;

   // ------------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] call  = 4'd0;
   logic       step;
   logic       dir;
   logic [1:0] floor;
   logic [3:0] pending;
   logic       door_open;
   logic       busy;
   logic [1:0] state;
`ifdef DISPATCH_SEG_EN
   logic [0:6] seg;
`endif

   always #5 clk = ~clk;

   elevator_dispatch #(
      .TRAVEL_CYC (TRAVEL_CYC),
      .DOOR_CYC   (DOOR_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .call      (call),
      .step      (step),
      .dir       (dir),
      .floor     (floor),
      .pending   (pending),
      .door_open (door_open),
      .busy      (busy),
      .state     (state)
`ifdef DISPATCH_SEG_EN
      ,
      .seg       (seg)
`endif
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   int          n_checks = 0;
   int          n_errs   = 0;
   logic [11:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] ev(input logic [1:0] kind, input logic d,
                                      input logic [1:0] f, input int aux);
      logic [6:0] a;
      a = aux[6:0];
      return {kind, d, f, a};
   endfunction

   task automatic exp_step(input logic d, input logic [1:0] from_floor);
      exp_q.push_back(ev(K_STEP, d, from_floor, TRAVEL_CYC));
   endtask

   task automatic exp_stop(input logic [1:0] f, input int open_len);
      exp_q.push_back(ev(K_OPEN, 1'b0, f, 1));
      exp_q.push_back(ev(K_CLOSE, 1'b0, f, open_len));
   endtask

   task automatic emit(input logic [11:0] obs);
      check("evt_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
         check("evt", obs, exp_q.pop_front());
      end
   endtask

`ifdef DISPATCH_SEG_EN
   function automatic logic [6:0] seg_enc(input logic [1:0] f);
      case (f)
         2'd0:    return 7'b1001111;
         2'd1:    return 7'b0010010;
         2'd2:    return 7'b0000110;
         default: return 7'b1001100;
      endcase
   endfunction
`endif

   // ------------------------------------------------------------------------
   // Monitor (falling edge)
   // ------------------------------------------------------------------------
   int         gap        = 0;
   int         door_len   = 0;
   int         step_cnt   = 0;
   int         inv_err    = 0;
   logic       prev_door  = 1'b0;
   logic       prev_rst   = 1'b0;
   logic [1:0] prev_floor = 2'd0;

   always @(negedge clk) begin
      if (step) step_cnt++;
      if (rst_n) begin
         if (!busy) gap = 0;
         else gap = gap + 1;
         if (step && (state != ST_MOVE)) inv_err++;
         if (door_open && (state == ST_MOVE)) inv_err++;
         if (busy != (state != ST_IDLE)) inv_err++;
         if (step) begin
            emit(ev(K_STEP, dir, floor, gap));
            gap = 0;
         end
         if (door_open && !prev_door) emit(ev(K_OPEN, 1'b0, floor, gap));
         if (door_open) begin
            door_len = door_len + 1;
         end else if (prev_door) begin
            emit(ev(K_CLOSE, 1'b0, floor, door_len));
            door_len = 0;
         end
`ifdef DISPATCH_SEG_EN
         if (prev_rst) check("seg", {25'd0, seg}, {25'd0, seg_enc(prev_floor)});
`endif
      end else begin
         gap      = 0;
         door_len = 0;
      end
      prev_door  = door_open & rst_n;
      prev_floor = floor;
      prev_rst   = rst_n;
   end

   // ------------------------------------------------------------------------
   // Driver tasks (called at posedge + 1)
   // ------------------------------------------------------------------------
   task automatic pulse_call(input logic [3:0] c, input int cycles);
      call = c;
      repeat (cycles) @(posedge clk);
      #1 call = 4'd0;
   endtask

   task automatic wait_idle(input int budget);
      int   k;
      logic done;
      k    = 0;
      done = 1'b0;
      while (!done && (k < budget)) begin
         @(negedge clk);
         k++;
         if (!busy && (pending == 4'd0) && (exp_q.size() == 0)) done = 1'b1;
      end
      check("idle_reached", done, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic end_scenario(input string tag);
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int saved_steps;

      rst_n = 1'b0;
      call  = 4'b1010;  // ignored while in reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_floor", floor, 0);
      check("rst_dir", dir, 1);
      check("rst_pending", pending, 0);
      check("rst_step", step, 0);
      check("rst_door", door_open, 0);
      check("rst_busy", busy, 0);
      check("rst_state", state, ST_IDLE);
      @(posedge clk);
      #1 rst_n = 1'b1;
      call = 4'd0;
      repeat (2) @(posedge clk);
      #1;

      // Single call two floors up.
      exp_step(1'b1, 2'd0);
      exp_step(1'b1, 2'd1);
      exp_stop(2'd2, DOOR_CYC);
      pulse_call(4'b0100, 1);
      wait_idle(200);
      check("s1_floor", floor, 2);
      check("s1_dir", dir, 1);
      check("s1_pending", pending, 0);
      check("s1_busy", busy, 0);
      end_scenario("s1_queue");

      // Return to floor 0, then calls at the current floor.
      exp_step(1'b0, 2'd2);
      exp_step(1'b0, 2'd1);
      exp_stop(2'd0, DOOR_CYC);
      pulse_call(4'b0001, 1);
      wait_idle(200);
      check("s2_floor", floor, 0);
      exp_stop(2'd0, DOOR_CYC);
      pulse_call(4'b0001, 1);
      wait_idle(100);
      // Held for 10 cycles: door opens 2 cycles after the call starts and
      // the timer restarts on every held cycle, giving 10 + 3 open cycles.
      exp_stop(2'd0, 13);
      pulse_call(4'b0001, 10);
      wait_idle(100);
      check("s2_floor_end", floor, 0);
      end_scenario("s2_queue");

      // Up to floor 1, then a trip to 3 with a call at 0 placed mid-travel.
      exp_step(1'b1, 2'd0);
      exp_stop(2'd1, DOOR_CYC);
      pulse_call(4'b0010, 1);
      wait_idle(200);
      exp_step(1'b1, 2'd1);
      exp_step(1'b1, 2'd2);
      exp_stop(2'd3, DOOR_CYC);
      exp_step(1'b0, 2'd3);
      exp_step(1'b0, 2'd2);
      exp_step(1'b0, 2'd1);
      exp_stop(2'd0, DOOR_CYC);
      pulse_call(4'b1000, 1);
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1;
      check("s3_moving", state, ST_MOVE);
      pulse_call(4'b0001, 1);
      wait_idle(400);
      check("s3_floor", floor, 0);
      check("s3_dir", dir, 0);
      end_scenario("s3_queue");

      // Top floor, call at top, then all the way down with no wrap.
      exp_step(1'b1, 2'd0);
      exp_step(1'b1, 2'd1);
      exp_step(1'b1, 2'd2);
      exp_stop(2'd3, DOOR_CYC);
      pulse_call(4'b1000, 1);
      wait_idle(300);
      check("s4_top", floor, 3);
      exp_stop(2'd3, DOOR_CYC);
      pulse_call(4'b1000, 1);
      wait_idle(100);
      exp_step(1'b0, 2'd3);
      exp_step(1'b0, 2'd2);
      exp_step(1'b0, 2'd1);
      exp_stop(2'd0, DOOR_CYC);
      pulse_call(4'b0001, 1);
      wait_idle(300);
      repeat (20) @(posedge clk);
      #1;
      check("s4_floor", floor, 0);
      check("s4_dir", dir, 0);
      end_scenario("s4_queue");

      // Reset in MOVE cycle 5 of 8 with calls asserted during reset.
      saved_steps = step_cnt;
      pulse_call(4'b0100, 1);
      repeat (5) @(posedge clk);
      #1;
      check("s5_in_move", state, ST_MOVE);
      rst_n = 1'b0;
      call  = 4'b1111;
      @(posedge clk);
      #1 rst_n = 1'b1;
      call = 4'd0;
      repeat (3) @(negedge clk);
      check("s5_no_step", step_cnt, saved_steps);
      check("s5_floor", floor, 0);
      check("s5_pending", pending, 0);
      check("s5_busy", busy, 0);
      check("s5_dir", dir, 1);
      @(posedge clk);
      #1;
      exp_step(1'b1, 2'd0);
      exp_stop(2'd1, DOOR_CYC);
      pulse_call(4'b0010, 1);
      wait_idle(200);
      check("s5_recover", floor, 1);
      end_scenario("s5_queue");

      check("invariants", inv_err, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/elevator_dispatch.md
ELEVATOR_DISPATCH -- requirements
Module: elevator_dispatch

Interface
REQ-001 Parameter: TRAVEL_CYC, default 8, clock cycles spent travelling one floor (legal range 2..255).
REQ-002 Parameter: DOOR_CYC, default 5, clock cycles the door stays open per stop (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 call  input  4  floor call buttons, bit i = floor i (0 = bottom, 3 = top), level-sensitive, synchronous to clk.
REQ-006 step  output  1  one-cycle pulse commanding the floor sequencer to move one floor in direction dir.
REQ-007 dir  output  1  travel direction, 1 = up, 0 = down; valid whenever step = 1 and held between steps.
REQ-008 floor  output  2  current floor index as tracked by this block.
REQ-009 pending  output  4  latched outstanding requests.
REQ-010 door_open  output  1  high while stopped with the door open.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, MOVE, DOOR; encoded in a registered state variable.
REQ-013 Request latch: each edge, pending <= (pending | call) with the current-floor bit cleared when entering DOOR or while in DOOR.
REQ-014 IDLE, pending[floor]=1: next state DOOR; no step issued.
REQ-015 IDLE, requests elsewhere: choose dir by SCAN -- keep last dir if any request lies beyond floor in that direction, else reverse; enter MOVE with travel timer loaded.
REQ-016 IDLE, pending = 0: remain IDLE; dir holds last value.
REQ-017 MOVE: step = 1 on exactly the TRAVEL_CYC-th cycle in MOVE; on that same edge floor increments (dir=1) or decrements (dir=0).
REQ-018 After a step: new floor pending -> DOOR; else requests further in dir -> MOVE with timer reloaded; else -> IDLE.
REQ-019 DOOR: door_open = 1 for DOOR_CYC cycles, then IDLE; a call at the current floor during DOOR restarts the door timer.
REQ-020 Boundaries: floor never steps below 0 or above 3 (no wrap); dir forced to 1 at floor 0 and 0 at floor 3 when leaving IDLE.
REQ-021 Simultaneous call and step: a call at the floor being arrived at in that cycle is honoured as a stop.
REQ-022 Calls at floors already passed while in MOVE stay latched and are served after reversal.
REQ-023 step is never asserted in IDLE or DOOR; door_open is never asserted in MOVE.

Reset
REQ-024 rst_n=0 at a rising edge: state IDLE, floor 0, dir 1, pending 0, step 0, door_open 0, busy 0, timers 0.
REQ-025 Reset mid-MOVE or mid-DOOR aborts immediately; no step pulse is emitted in the reset cycle or the cycle after release.
REQ-026 call is ignored during any cycle rst_n=0.

Configuration
REQ-027 Macro DISPATCH_SEG_EN defined: extra output seg[0:6], registered, active-low seven-segment digit of floor+1 (1=1001111, 2=0010010, 3=0000110, 4=1001100), reset value 1001111.
REQ-028 Macro DISPATCH_SEG_EN undefined: seg port and its logic absent; all other behaviour identical.

Verification
REQ-029 Reset, then call=0100 one cycle (TRAVEL_CYC=8) -> two step pulses with dir=1, 8 cycles apart, floor 0->1->2, then door_open high 5 cycles, pending=0, busy low.
REQ-030 At floor 0, call=0001 -> no step, door_open 5 cycles; hold call=0001 during DOOR -> door timer restarts, door_open stays high.
REQ-031 At floor 1 moving up to 3, call floor 0 mid-travel -> stops at 3 first, then dir=0, three steps down to floor 0.
REQ-032 At floor 3, call=1000 then call=0001 -> dir=0, no step beyond floor 0, no wrap to 3.
REQ-033 rst_n low 1 cycle mid-MOVE at cycle 5 of 8 -> floor 0, pending 0, no step for at least 2 cycles after release.
REQ-034 DISPATCH_SEG_EN defined: traverse floors 0..3 -> seg sequence 1001111, 0010010, 0000110, 1001100 one cycle after each floor change.
